// File: rtl/boreal_pkg.sv
// Shared types and constants for the Hebbian weight-update path.
// Widths, saturation limits and the per-stage pipeline record.
package boreal_pkg;

  localparam int ADDR_W       = 10;
  localparam int DATA_W       = 16;
  localparam int LR_SHIFT_DEF = 4;

  localparam logic [DATA_W-1:0] W_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] W_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] delta;
  } stage_t;

endpackage

// File: rtl/boreal_sat_add.sv
// Scales a delta by the learning-rate shift and adds it to a weight.
// The sum clamps to the signed range; sat_o flags a clamped result.
module boreal_sat_add
  import boreal_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int LR_SHIFT   = LR_SHIFT_DEF
) (
  input  logic [DATA_WIDTH-1:0] weight_i,
  input  logic [DATA_WIDTH-1:0] delta_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  sat_o
);

  localparam logic [DATA_WIDTH-1:0] MAXV =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MINV =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] eff;
  logic        [DATA_WIDTH:0]   wide;

  // Sign-extended add one bit wide; top two bits disagree on overflow.
  always_comb begin
    eff   = $signed(delta_i) >>> LR_SHIFT;
    wide  = {weight_i[DATA_WIDTH-1], weight_i}
          + {eff[DATA_WIDTH-1], eff};
    sat_o = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
    sum_o = wide[DATA_WIDTH-1:0];
    if (sat_o) begin
      sum_o = wide[DATA_WIDTH] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/boreal_hebbian_updater.sv
// Read-modify-write engine applying plasticity deltas to weight memory.
// Four stages: read address, memory register, compute, write-back.
module boreal_hebbian_updater
  import boreal_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int LR_SHIFT   = LR_SHIFT_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  logic [DATA_WIDTH-1:0] upd_delta,
  output logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] dout_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] din_b,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  upd_count,
  output logic [CNT_WIDTH-1:0]  sat_count
);

  stage_t s1_q, s1_d, s2_q, s3_q;

  logic                  we_q;
  logic                  sat_q;
  logic [ADDR_WIDTH-1:0] addr_b_q;
  logic [DATA_WIDTH-1:0] din_b_q;
  logic [CNT_WIDTH-1:0]  upd_cnt_q;
  logic [CNT_WIDTH-1:0]  sat_cnt_q;

  logic                  hit;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sum;
  logic                  sat;

  // Stall on any in-flight address match; the write stage counts too
  // because the memory returns old data on a same-edge read.
  always_comb begin
    hit = (s1_q.valid && s1_q.addr == upd_addr)
       || (s2_q.valid && s2_q.addr == upd_addr)
       || (s3_q.valid && s3_q.addr == upd_addr)
       || (we_q && addr_b_q == upd_addr);
    upd_ready = !hit;
    accept    = upd_valid && upd_ready;
  end

  // S1 takes the new request, else keeps its address with valid low.
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = 1'b0;
    if (accept) begin
      s1_d.valid = 1'b1;
      s1_d.addr  = upd_addr;
      s1_d.delta = upd_delta;
    end
  end

  boreal_sat_add #(
    .DATA_WIDTH (DATA_WIDTH),
    .LR_SHIFT   (LR_SHIFT)
  ) u_sat_add (
    .weight_i (dout_a),
    .delta_i  (s3_q.delta),
    .sum_o    (sum),
    .sat_o    (sat)
  );

  // Advance the read-side stages in lockstep with the memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_q.valid || s1_q.valid ? s1_q : s2_q;
      s3_q <= s3_q.valid || s2_q.valid ? s2_q : s3_q;
    end
  end

  // Register the write-back; data and address hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      sat_q    <= 1'b0;
      addr_b_q <= '0;
      din_b_q  <= '0;
    end else begin
      we_q  <= s3_q.valid;
      sat_q <= s3_q.valid && sat;
      if (s3_q.valid) begin
        addr_b_q <= s3_q.addr;
        din_b_q  <= sum;
      end
    end
  end

  // Count completed and clamped writes; both wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_cnt_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      if (we_q) begin
        upd_cnt_q <= upd_cnt_q + 1'b1;
      end
      if (we_q && sat_q) begin
        sat_cnt_q <= sat_cnt_q + 1'b1;
      end
    end
  end

  assign addr_a    = s1_q.addr;
  assign we_b      = we_q;
  assign addr_b    = addr_b_q;
  assign din_b     = din_b_q;
  assign busy      = s1_q.valid || s2_q.valid
                  || s3_q.valid || we_q;
  assign upd_count = upd_cnt_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_boreal_hebbian_updater.sv
// Bench for the Hebbian updater with a read-first 2-cycle weight store.
// Expected writes come from a shadow weight model via a scoreboard.
module tb_boreal_hebbian_updater;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [9:0]  upd_addr;
  logic [15:0] upd_delta;
  logic [9:0]  addr_a;
  logic [15:0] dout_a;
  logic        we_b;
  logic [9:0]  addr_b;
  logic [15:0] din_b;
  logic        busy;
  logic [15:0] upd_count;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  boreal_hebbian_updater dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_addr  (upd_addr),
    .upd_delta (upd_delta),
    .addr_a    (addr_a),
    .dout_a    (dout_a),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .din_b     (din_b),
    .busy      (busy),
    .upd_count (upd_count),
    .sat_count (sat_count)
  );

  // Read-first store: address sampled, internal register, output.
  logic [15:0] ram [1024];
  logic [15:0] mdl [1024];
  logic [15:0] rd1;

  always @(posedge clk) begin
    rd1    <= ram[addr_a];
    dout_a <= rd1;
    if (we_b) ram[addr_b] <= din_b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    bit          sat;
    int          acc;
    logic [15:0] old;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int ntot = 0;
  int npass = 0;
  int exp_upd = 0;
  int exp_sat = 0;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] want);
    ntot++;
    if (act === want) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask

  // Every write must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && we_b) begin
      if (q.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_write: addr %0h data %0h",
                 addr_b, din_b);
      end else begin
        mon_e = q.pop_front();
        check("wr_addr", 32'(addr_b), 32'(mon_e.addr));
        check("wr_data", 32'(din_b), 32'(mon_e.data));
        check("wr_latency", cyc, mon_e.acc + 4);
        exp_upd++;
        if (mon_e.sat) exp_sat++;
      end
    end
  end

  task automatic preload(input logic [9:0] a,
                         input logic [15:0] v);
    ram[a] = v;
    mdl[a] = v;
  endtask

  task automatic push(input logic [9:0] a,
                      input logic [15:0] d);
    exp_t e;
    int dv;
    int s;
    dv = int'($signed(d));
    dv = dv >>> 4;
    s = int'($signed(mdl[a])) + dv;
    e.sat = 1'b0;
    if (s > 32767) begin
      s = 32767;
      e.sat = 1'b1;
    end else if (s < -32768) begin
      s = -32768;
      e.sat = 1'b1;
    end
    e.addr = a;
    e.data = s[15:0];
    e.old = mdl[a];
    e.acc = cyc;
    mdl[a] = e.data;
    q.push_back(e);
  endtask

  // Present a request and hold it until accepted; count stall cycles.
  task automatic send(input logic [9:0] a,
                      input logic [15:0] d,
                      output int stalls);
    stalls = 0;
    @(negedge clk);
    upd_valid = 1'b1;
    upd_addr = a;
    upd_delta = d;
    #1;
    while (!upd_ready && stalls < 20) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!upd_ready) begin
      ntot++;
      $display("FAIL send_timeout: addr %0h", a);
    end else begin
      push(a, d);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      ntot++;
      $display("FAIL drain_timeout: busy %0b pending %0d",
               busy, q.size());
    end
    @(negedge clk);
  endtask

  task automatic flush_model();
    exp_t e;
    while (q.size() != 0) begin
      e = q.pop_back();
      mdl[e.addr] = e.old;
    end
    exp_upd = 0;
    exp_sat = 0;
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] delta;
    logic [15:0] init;
    logic [15:0] want;
    int          sat;
  } vec_t;

  vec_t vt[6];

  initial begin
    int st;
    int st2;
    int tot_st;
    int sat_acc;
    int s0;

    vt[0] = '{10'd5,  16'h0040, 16'h0100, 16'h0104, 0};
    vt[1] = '{10'd9,  16'h7FFF, 16'h7FF0, 16'h7FFF, 1};
    vt[2] = '{10'd10, 16'h8000, 16'h8005, 16'h8000, 1};
    vt[3] = '{10'd11, 16'hFFF0, 16'h0000, 16'hFFFF, 0};
    vt[4] = '{10'd12, 16'h0008, 16'h0003, 16'h0003, 0};
    vt[5] = '{10'd13, 16'h8000, 16'h7FFF, 16'h77FF, 0};

    for (int i = 0; i < 1024; i++) begin
      ram[i] = 16'h0;
      mdl[i] = 16'h0;
    end
    rst_n = 1'b0;
    upd_valid = 1'b0;
    upd_addr = '0;
    upd_delta = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_ready", 32'(upd_ready), 1);
    check("rst_addr_a", 32'(addr_a), 0);
    check("rst_we_b", 32'(we_b), 0);
    check("rst_addr_b", 32'(addr_b), 0);
    check("rst_din_b", 32'(din_b), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_upd_count", 32'(upd_count), 0);
    check("rst_sat_count", 32'(sat_count), 0);

    // Single updates and saturation corners.
    sat_acc = 0;
    for (int i = 0; i < 6; i++) begin
      preload(vt[i].addr, vt[i].init);
      s0 = int'(sat_count);
      send(vt[i].addr, vt[i].delta, st);
      idle();
      drain();
      sat_acc += vt[i].sat;
      check("tbl_ram", 32'(ram[vt[i].addr]), 32'(vt[i].want));
      check("tbl_upd_count", 32'(upd_count), i + 1);
      check("tbl_sat_step", int'(sat_count) - s0, vt[i].sat);
      check("tbl_sat_total", 32'(sat_count), sat_acc);
    end

    // Streaming to distinct addresses.
    for (int i = 0; i < 8; i++) preload(10'(i), 16'h0);
    tot_st = 0;
    for (int i = 0; i < 8; i++) begin
      send(10'(i), 16'h0010, st);
      tot_st += st;
    end
    idle();
    #1;
    check("stream_busy", 32'(busy), 1);
    drain();
    check("stream_stalls", tot_st, 0);
    for (int i = 0; i < 8; i++)
      check("stream_ram", 32'(ram[i]), 32'h0001);
    check("stream_upd_count", 32'(upd_count), exp_upd);

    // Same address back-to-back.
    preload(10'd3, 16'h0);
    send(10'd3, 16'h0010, st);
    send(10'd3, 16'h0010, st2);
    idle();
    drain();
    check("raw_first_stall", st, 0);
    check("raw_stall", st2, 4);
    check("raw_ram", 32'(ram[3]), 32'h0002);

    // Interleaved hazard 4, 7, 4.
    preload(10'd4, 16'h0);
    preload(10'd7, 16'h0);
    send(10'd4, 16'h0010, st);
    send(10'd7, 16'h0010, st);
    check("ilv_7_stall", st, 0);
    send(10'd4, 16'h0010, st);
    check("ilv_4_stall", st, 3);
    idle();
    drain();
    check("ilv_ram4", 32'(ram[4]), 32'h0002);
    check("ilv_ram7", 32'(ram[7]), 32'h0001);
    check("ilv_upd_count", 32'(upd_count), exp_upd);
    check("ilv_sat_count", 32'(sat_count), exp_sat);

    // Reset in the cycle after the third accept.
    for (int i = 20; i < 23; i++) preload(10'(i), 16'h0050);
    for (int i = 20; i < 23; i++) send(10'(i), 16'h0100, st);
    @(negedge clk);
    upd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_we_b", 32'(we_b), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_ready", 32'(upd_ready), 1);
    check("mrst_upd_count", 32'(upd_count), 0);
    check("mrst_sat_count", 32'(sat_count), 0);
    flush_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 20; i < 23; i++)
      check("mrst_ram", 32'(ram[i]), 32'h0050);
    check("mrst_upd_after", 32'(upd_count), 0);

    // Reset while the write is being presented.
    preload(10'd30, 16'h0010);
    send(10'd30, 16'h0100, st);
    idle();
    repeat (3) @(negedge clk);
    #2;
    check("arst_we_pre", 32'(we_b), 1);
    rst_n = 1'b0;
    #1;
    check("arst_we_b", 32'(we_b), 0);
    flush_model();
    mdl[30] = 16'h0010;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_ram", 32'(ram[30]), 32'h0010);
    check("arst_upd_count", 32'(upd_count), 0);
    check("arst_ready", 32'(upd_ready), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/boreal_hebbian_updater.md
# boreal_hebbian_updater

Read-modify-write engine that applies Hebbian plasticity deltas to the synaptic weight store. It accepts a stream of (address, signed delta) update requests, reads the current weight through the store's read port (2-cycle latency), scales and saturating-adds the delta, and writes the result back through the store's write port. It sits between the plasticity rule logic and `boreal_memory`, and is the sole driver of that memory's port A address and port B write signals.

## Interface
- `ADDR_WIDTH`, 10, weight address width; matches `boreal_memory`.
- `DATA_WIDTH`, 16, weight and delta width; signed two's complement fixed point.
- `LR_SHIFT`, 4, learning-rate right shift (arithmetic) applied to each delta.
- `CNT_WIDTH`, 16, width of the status counters.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `upd_valid` in 1: update request valid.
- `upd_ready` out 1: engine can accept this cycle.
- `upd_addr` in ADDR_WIDTH: weight address to update.
- `upd_delta` in DATA_WIDTH: signed raw delta.
- `addr_a` out ADDR_WIDTH: registered read address to memory port A.
- `dout_a` in DATA_WIDTH: read data from port A; valid 2 cycles after `addr_a` is presented.
- `we_b` out 1: registered write enable to port B.
- `addr_b` out ADDR_WIDTH: registered write address.
- `din_b` out DATA_WIDTH: registered write data.
- `busy` out 1: any pipeline stage valid.
- `upd_count` out CNT_WIDTH: completed writes; wraps at 2^CNT_WIDTH.
- `sat_count` out CNT_WIDTH: writes that clamped; wraps.

## Operation
- Four-stage pipeline with per-stage valid, address and delta:
  - **S1:** `addr_a` driven.
  - **S2:** memory internal register.
  - **S3:** `dout_a` valid; compute.
  - **S4:** `we_b` high.
- Accept occurs when `upd_valid && upd_ready` at a rising edge. At that edge, `addr_a <= upd_addr` and S1 is loaded.
- Compute in S3:
  - `eff = upd_delta >>> LR_SHIFT`, sign-extended.
  - `sum = sext(dout_a) + sext(eff)` at DATA_WIDTH+1 bits.
  - Clamp to `0x7FFF`/`0x8000` (generic: max/min signed).
  - The result is registered into `din_b`/`addr_b`, with `we_b` = 1 for one cycle.
- Hazard rule: `upd_ready` = 0 whenever `upd_addr` equals the address of any valid stage S1..S4. Otherwise `upd_ready` = 1. `upd_ready` depends combinationally on `upd_addr` and stage state, not on `upd_valid`.
  - The S4 match covers the same-edge read/write case, since the memory is read-first. A read sampled together with the write would return stale data.
- No forwarding; stall only.
- Distinct addresses sustain one update per cycle.
- `upd_count` increments on each cycle `we_b` = 1.
- `sat_count` increments additionally when that write clamped.
- When `upd_valid` = 0, `addr_a` holds its last value and S1 loads invalid. Reads with S1 invalid are harmless.

## Timing
- Accept at edge E0:
  - `addr_a` = new address in cycle C1.
  - `dout_a` valid in C3.
  - `we_b`/`addr_b`/`din_b` asserted in C4.
  - RAM updated at E4.
- Accept-to-write latency is 4 cycles.
- Same-address back-to-back: the second request is held with `upd_ready` = 0 in C1–C4 and accepted at E5 at the earliest.
- `busy` is high from C1 until the cycle after the last `we_b`.
- Reset values: `upd_ready` 1 (no stages valid), `addr_a` 0, `we_b` 0, `addr_b` 0, `din_b` 0, `busy` 0, `upd_count` 0, `sat_count` 0, all stage valids 0.
- Reset mid-operation: all in-flight updates are dropped. `we_b` goes to 0 asynchronously on `rst_n` fall, and no write is issued for requests accepted before reset.
- Counters wrap silently; no sticky overflow.

## Structure
- Shared package `boreal_pkg` holds:
  - Weight/delta width constants.
  - Signed max/min weight constants (`W_MAX`, `W_MIN`).
  - Default `LR_SHIFT`.
  - The stage record typedef (valid, addr, delta).
- One sub-module, `boreal_sat_add`: combinational scale-shift plus saturating signed add. Outputs are `sum` and `sat` flag.
- Top level holds the pipeline registers, hazard comparators and counters.

## Test plan
Benches instantiate `boreal_memory` as the store. All scenarios use default parameters.
1. **Single update:** ram[5]=`0x0100`; accept addr 5, delta `0x0040` → `we_b` 4 cycles later with `addr_b`=5, `din_b`=`0x0104`; `upd_count`=1.
2. **Streaming:** addrs 0..7 on consecutive cycles, delta `0x0010`, ram=0 → `upd_ready` never drops; 8 consecutive `we_b` cycles, each writing `0x0001`; first write 4 cycles after first accept.
3. **RAW hazard:** ram[3]=0; addr 3 delta `0x0010` twice back-to-back → `upd_ready` low 4 cycles; second accepted at E5; final ram[3]=`0x0002`.
4. **Saturation:**
   - ram[9]=`0x7FF0`, delta `0x7FFF` → `din_b`=`0x7FFF`.
   - ram[10]=`0x8005`, delta `0x8000` → `din_b`=`0x8000`.
   - `sat_count`=2.
5. **Reset mid-flight:** accept 3 updates, drop `rst_n` in the cycle after the third accept → `we_b` 0 immediately; no writes after release; counters 0; `upd_ready`=1.
6. **Interleaved hazard:** addrs 4, 7, 4 requested back-to-back → second 4 stalls until the first 4's write commits; ram[7] is written with no stall.
